// File: rtl/roy1707018_tdc_pkg.sv
// Shared types and constants for the counter-based time-to-digital converter.
// Holds the FSM states, readout select codes and status-byte bit positions.
package tdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdc_state_e;

  localparam int CNT_W  = 16;
  localparam int MEAS_W = 5;

  localparam logic [1:0] SEL_RES_LO = 2'b00;
  localparam logic [1:0] SEL_RES_HI = 2'b01;
  localparam logic [1:0] SEL_STATUS = 2'b10;
  localparam logic [1:0] SEL_ZERO   = 2'b11;

  // Status byte layout: {valid, busy, overflow, meas_cnt[4:0]}
  localparam int STAT_VALID    = 7;
  localparam int STAT_BUSY     = 6;
  localparam int STAT_OVF      = 5;
  localparam int STAT_MEAS_LSB = 0;

endpackage

// File: rtl/roy1707018_tdc_sync_edge.sv
// N-stage synchronizer followed by a rising-edge detector on the synced value.
// The pulse is combinational from the last stage and its delayed copy.
module tdc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic pulse
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (srst) sync_reg[gi] <= 1'b0;
          else      sync_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (srst) sync_reg[gi] <= 1'b0;
          else      sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) prev_reg <= 1'b0;
    else      prev_reg <= sync_reg[STAGES-1];
  end

  assign pulse = sync_reg[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/roy1707018_tdc.sv
// Time-to-digital converter: counts clk cycles between start and stop rising edges
// and exposes the 16-bit result and a status byte on an 8-bit readout bus.
module roy1707018_tdc
  import tdc_pkg::*;
#(
  parameter int CNT_W       = tdc_pkg::CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic start_pulse;
  logic stop_pulse;

  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clk   (clk),
    .srst  (srst),
    .d     (ui_in[0]),
    .pulse (start_pulse)
  );

  tdc_sync_edge #(.STAGES(SYNC_STAGES)) u_stop_sync (
    .clk   (clk),
    .srst  (srst),
    .d     (ui_in[1]),
    .pulse (stop_pulse)
  );

  logic unused_ui;
  assign unused_ui = ^ui_in[7:4];

  tdc_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  result_reg, result_next;
  logic              valid_reg, valid_next;
  logic              overflow_reg, overflow_next;
  logic [MEAS_W-1:0] meas_cnt_reg, meas_cnt_next;
  logic [CNT_W-1:0]  cnt_inc;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      result_reg   <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      meas_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      valid_reg    <= valid_next;
      overflow_reg <= overflow_next;
      meas_cnt_reg <= meas_cnt_next;
    end
  end

  assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    valid_next    = valid_reg;
    overflow_next = overflow_reg;
    meas_cnt_next = meas_cnt_reg;

    // A start edge (re)arms from zero in either state; a coincident stop captures 0.
    if (start_pulse) begin
      cnt_next      = '0;
      overflow_next = 1'b0;
      valid_next    = 1'b0;
      state_next    = RUN;
      if (stop_pulse) begin
        result_next   = '0;
        valid_next    = 1'b1;
        meas_cnt_next = meas_cnt_reg + MEAS_W'(1);
        state_next    = IDLE;
      end
    end else if (state_reg == RUN) begin
      cnt_next = cnt_inc;
      if (cnt_inc == CNT_MAX) overflow_next = 1'b1;
      if (stop_pulse) begin
        result_next   = cnt_inc;
        valid_next    = 1'b1;
        meas_cnt_next = meas_cnt_reg + MEAS_W'(1);
        state_next    = IDLE;
      end
    end
  end

  logic [7:0] status;

  always_comb begin
    status                                      = '0;
    status[STAT_VALID]                          = valid_reg;
    status[STAT_BUSY]                           = (state_reg == RUN);
    status[STAT_OVF]                            = overflow_reg;
    status[STAT_MEAS_LSB +: MEAS_W]             = meas_cnt_reg;
  end

  always_comb begin
    uo_out = 8'h00;
    case (ui_in[3:2])
      SEL_RES_LO: uo_out = result_reg[7:0];
      SEL_RES_HI: uo_out = result_reg[15:8];
      SEL_STATUS: uo_out = status;
      SEL_ZERO:   uo_out = 8'h00;
      default:    uo_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_roy1707018_tdc.sv
// Self-checking bench for roy1707018_tdc: timestamp-based reference model checked
// every cycle, plus directed scenarios with hand-computed readout bytes.
module tb_roy1707018_tdc;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int total = 0;
  int bad   = 0;

  roy1707018_tdc #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut (
    .clk    (clk),
    .srst   (srst),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  always #5 clk = ~clk;

  // Reference model: measurement = difference of edge timestamps, delayed by SYNC edges.
  longint cyc = 0;
  longint start_q[$];
  longint stop_q[$];
  logic   prev_start = 1'b0, prev_stop = 1'b0;
  logic   m_busy = 1'b0, m_valid = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_result = '0;
  logic [4:0]  m_meas = '0;
  longint t0 = 0;

  function automatic logic [7:0] model_out(input logic [1:0] sel);
    case (sel)
      2'b00:   return m_result[7:0];
      2'b01:   return m_result[15:8];
      2'b10:   return {m_valid, m_busy, m_ovf, m_meas};
      default: return 8'h00;
    endcase
  endfunction

  always begin
    @(posedge clk);
    cyc++;
    if (srst) begin
      start_q.delete();
      stop_q.delete();
      prev_start = 1'b0;
      prev_stop  = 1'b0;
      m_busy = 1'b0; m_valid = 1'b0; m_ovf = 1'b0;
      m_result = '0; m_meas = '0;
    end else begin
      if (start_q.size() > 0 && start_q[0] == cyc) begin
        void'(start_q.pop_front());
        m_busy = 1'b1; m_valid = 1'b0; m_ovf = 1'b0; t0 = cyc;
      end
      if (stop_q.size() > 0 && stop_q[0] == cyc) begin
        void'(stop_q.pop_front());
        if (m_busy) begin
          if (cyc - t0 >= 64'hFFFF) begin
            m_result = 16'hFFFF;
            m_ovf    = 1'b1;
          end else begin
            m_result = 16'(cyc - t0);
          end
          m_valid = 1'b1;
          m_meas  = m_meas + 5'd1;
          m_busy  = 1'b0;
        end
      end
      if (m_busy && (cyc - t0 >= 64'hFFFF)) m_ovf = 1'b1;
      if (ui_in[0] && !prev_start) start_q.push_back(cyc + SYNC);
      if (ui_in[1] && !prev_stop)  stop_q.push_back(cyc + SYNC);
      prev_start = ui_in[0];
      prev_stop  = ui_in[1];
    end
    #1;
    total++;
    if (uo_out !== model_out(ui_in[3:2])) begin
      bad++;
      $display("FAIL model cyc=%0d sel=%0d got=%02h exp=%02h", cyc, ui_in[3:2], uo_out,
               model_out(ui_in[3:2]));
    end
  end

  task automatic chk_sel(input logic [1:0] sel, input logic [7:0] exp, input string name);
    ui_in[3:2] = sel;
    #1;
    total++;
    if (uo_out !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", name, uo_out, exp);
    end else begin
      $display("check %s sel=%0d value=%02h ok", name, sel, uo_out);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    ui_in[0] = 1'b1;
    @(negedge clk);
    ui_in[0] = 1'b0;
  endtask

  task automatic pulse_stop;
    ui_in[1] = 1'b1;
    @(negedge clk);
    ui_in[1] = 1'b0;
  endtask

  task automatic measure(input int d);
    pulse_start;
    wait_cyc(d - 1);
    pulse_stop;
    wait_cyc(4);
  endtask

  task automatic do_reset(input int n);
    srst = 1'b1;
    wait_cyc(n);
    srst = 1'b0;
  endtask

  initial begin
    srst  = 1'b1;
    ui_in = 8'h00;
    @(negedge clk);
    do_reset(2);
    chk_sel(2'b00, 8'h00, "reset_lo");
    chk_sel(2'b01, 8'h00, "reset_hi");
    chk_sel(2'b10, 8'h00, "reset_status");
    chk_sel(2'b11, 8'h00, "reset_zero");

    ui_in[3:2] = 2'b10;
    wait_cyc(7);
    measure(100);
    chk_sel(2'b00, 8'h64, "basic_lo");
    chk_sel(2'b01, 8'h00, "basic_hi");
    chk_sel(2'b10, 8'h81, "basic_status");

    ui_in[3:2] = 2'b00;
    measure(16'h1234);
    chk_sel(2'b00, 8'h34, "long_lo");
    chk_sel(2'b01, 8'h12, "long_hi");
    chk_sel(2'b10, 8'h82, "long_status");

    ui_in[3:2] = 2'b10;
    measure(70000);
    chk_sel(2'b00, 8'hFF, "ovf_lo");
    chk_sel(2'b01, 8'hFF, "ovf_hi");
    chk_sel(2'b10, 8'hA3, "ovf_status");

    ui_in[1:0] = 2'b11;
    @(negedge clk);
    ui_in[1:0] = 2'b00;
    wait_cyc(4);
    chk_sel(2'b00, 8'h00, "same_lo");
    chk_sel(2'b01, 8'h00, "same_hi");
    chk_sel(2'b10, 8'h84, "same_status");

    pulse_stop;
    wait_cyc(4);
    chk_sel(2'b10, 8'h84, "stoponly_status");
    chk_sel(2'b00, 8'h00, "stoponly_lo");

    ui_in[3:2] = 2'b00;
    pulse_start;
    wait_cyc(49);
    pulse_start;
    wait_cyc(19);
    pulse_stop;
    wait_cyc(4);
    chk_sel(2'b00, 8'h14, "restart_lo");
    chk_sel(2'b10, 8'h85, "restart_status");

    pulse_start;
    wait_cyc(10);
    chk_sel(2'b10, 8'h45, "midrun_busy");
    do_reset(1);
    chk_sel(2'b10, 8'h00, "midrun_after_rst");
    pulse_stop;
    wait_cyc(4);
    chk_sel(2'b10, 8'h00, "midrun_status");
    chk_sel(2'b00, 8'h00, "midrun_lo");
    chk_sel(2'b11, 8'h00, "sel11_zero");

    wait_cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
